mod_rom_copy_dma: RTL and testbench

- Parametrised ROM-to-RAM copy engine with a host access port.
- Streams a compile-time table of segments from constant ROM into working RAM, one word per cycle. Each segment has a source, a destination and a length.
- Default table loads the SHA-256 initial hash words and round constants.
- After the copy completes, it arbitrates a single-ported synchronous RAM between the copy stream and the host (round datapath/controller).

---
 rtl/mod_memmgr_pkg.sv | 39 +++
 rtl/mod_seg_sequencer.sv | 123 ++++++++++++
 rtl/mod_rom_copy_dma.sv | 121 ++++++++++++
 tb/tb_mod_rom_copy_dma.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mod_memmgr_pkg.sv
// Shared types and default copy table for the ROM-to-RAM copy engine.
// The default table loads the SHA-256 initial hash words and round constants.
package mod_memmgr_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        STREAM = 2'd2,
        DRAIN  = 2'd3
    } copy_state_t;

    localparam int DEF_ROM_AW  = 13;
    localparam int DEF_RAM_AW  = 8;
    localparam int DEF_NUM_SEG = 2;

    // Segment 0: H0..H7 into RAM 0..7; segment 1: K0..K63 into RAM 64..127.
    localparam int H0_SRC = 0;
    localparam int H0_DST = 0;
    localparam int H0_LEN = 8;
    localparam int K_SRC  = 8;
    localparam int K_DST  = 64;
    localparam int K_LEN  = 64;

    // Packs two per-segment values of width w into one vector, entry 0 in the LSBs.
    function automatic logic [255:0] pack_seg(input int w, input int v0, input int v1);
        logic [255:0] mask;
        mask = (256'(1) << w) - 256'(1);
        return (256'(v0) & mask) | ((256'(v1) & mask) << w);
    endfunction

    localparam int DEF_SRC_W = DEF_NUM_SEG * DEF_ROM_AW;
    localparam int DEF_DST_W = DEF_NUM_SEG * DEF_RAM_AW;
    localparam int DEF_LEN_W = DEF_NUM_SEG * (DEF_RAM_AW + 1);

    localparam logic [DEF_SRC_W-1:0] DEF_SEG_SRC = DEF_SRC_W'(pack_seg(DEF_ROM_AW, H0_SRC, K_SRC));
    localparam logic [DEF_DST_W-1:0] DEF_SEG_DST = DEF_DST_W'(pack_seg(DEF_RAM_AW, H0_DST, K_DST));
    localparam logic [DEF_LEN_W-1:0] DEF_SEG_LEN = DEF_LEN_W'(pack_seg(DEF_RAM_AW + 1, H0_LEN, K_LEN));

endpackage

// File: rtl/mod_seg_sequencer.sv
// Walks the segment table one word per step, skipping empty segments, and
// produces the ROM read address plus the RAM write address one cycle behind it.
module mod_seg_sequencer
    import mod_memmgr_pkg::*;
#(
    parameter int ROM_AW  = 13,
    parameter int RAM_AW  = 8,
    parameter int NUM_SEG = 2,
    parameter logic [NUM_SEG*ROM_AW-1:0]     SEG_SRC = '0,
    parameter logic [NUM_SEG*RAM_AW-1:0]     SEG_DST = '0,
    parameter logic [NUM_SEG*(RAM_AW+1)-1:0] SEG_LEN = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic              step,
    output logic [ROM_AW-1:0] rom_addr,
    output logic [RAM_AW-1:0] ram_addr,
    output logic              wr_vld,
    output logic              last,
    output logic              empty
);

    localparam int LEN_W = RAM_AW + 1;
    localparam int SEG_W = $clog2(NUM_SEG + 1);

    if (NUM_SEG < 1 || NUM_SEG > 8) begin : g_num_err
        $error("NUM_SEG must be in 1..8");
    end

    for (genvar g = 0; g < NUM_SEG; g++) begin : g_chk
        localparam int SRC_END = int'(SEG_SRC[g*ROM_AW +: ROM_AW]) + int'(SEG_LEN[g*LEN_W +: LEN_W]);
        localparam int DST_END = int'(SEG_DST[g*RAM_AW +: RAM_AW]) + int'(SEG_LEN[g*LEN_W +: LEN_W]);
        if (SRC_END > (1 << ROM_AW)) begin : g_src_err
            $error("segment %0d overruns the ROM address space", g);
        end
        if (DST_END > (1 << RAM_AW)) begin : g_dst_err
            $error("segment %0d overruns the RAM address space", g);
        end
    end

    function automatic logic [ROM_AW-1:0] src_of(input int s);
        return SEG_SRC[s*ROM_AW +: ROM_AW];
    endfunction

    function automatic logic [RAM_AW-1:0] dst_of(input int s);
        return SEG_DST[s*RAM_AW +: RAM_AW];
    endfunction

    function automatic logic [LEN_W-1:0] len_of(input int s);
        return SEG_LEN[s*LEN_W +: LEN_W];
    endfunction

    // First segment at or after 'from' with a nonzero length; NUM_SEG if none.
    function automatic int next_nz(input int from);
        int r;
        r = NUM_SEG;
        for (int k = NUM_SEG - 1; k >= 0; k--) begin
            if (k >= from && len_of(k) != '0) r = k;
        end
        return r;
    endfunction

    logic [SEG_W-1:0]  seg;
    logic [LEN_W-1:0]  idx;
    logic [RAM_AW-1:0] dst_addr;
    logic              rd_vld;
    logic              seg_end;
    int                first_seg;
    int                next_seg;

    always_comb begin
        first_seg = next_nz(0);
        next_seg  = next_nz(int'(seg) + 1);
        seg_end   = (idx == LEN_W'(len_of(int'(seg)) - 1'b1));
        last      = rd_vld && seg_end && (next_seg == NUM_SEG);
        empty     = (first_seg == NUM_SEG);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg      <= '0;
            idx      <= '0;
            rd_vld   <= 1'b0;
            rom_addr <= '0;
            dst_addr <= '0;
            ram_addr <= '0;
            wr_vld   <= 1'b0;
        end else if (load) begin
            wr_vld <= 1'b0;
            idx    <= '0;
            if (first_seg < NUM_SEG) begin
                seg      <= SEG_W'(first_seg);
                rom_addr <= src_of(first_seg);
                dst_addr <= dst_of(first_seg);
                rd_vld   <= 1'b1;
            end else begin
                rd_vld <= 1'b0;
            end
        end else if (step && rd_vld) begin
            // Word read this cycle is written next cycle at the matching RAM address.
            wr_vld   <= 1'b1;
            ram_addr <= dst_addr;
            if (seg_end) begin
                idx <= '0;
                if (next_seg < NUM_SEG) begin
                    seg      <= SEG_W'(next_seg);
                    rom_addr <= src_of(next_seg);
                    dst_addr <= dst_of(next_seg);
                end else begin
                    rd_vld <= 1'b0;
                end
            end else begin
                idx      <= idx + 1'b1;
                rom_addr <= rom_addr + 1'b1;
                dst_addr <= dst_addr + 1'b1;
            end
        end else begin
            wr_vld <= 1'b0;
        end
    end

endmodule

// File: rtl/mod_rom_copy_dma.sv
// ROM-to-RAM copy engine: streams the segment table into RAM on a COPY_ROM
// edge, then hands the single-ported RAM to the host port.
module mod_rom_copy_dma
    import mod_memmgr_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int ROM_AW  = 13,
    parameter int RAM_AW  = 8,
    parameter int NUM_SEG = 2,
    parameter logic [NUM_SEG*ROM_AW-1:0]     SEG_SRC = DEF_SEG_SRC,
    parameter logic [NUM_SEG*RAM_AW-1:0]     SEG_DST = DEF_SEG_DST,
    parameter logic [NUM_SEG*(RAM_AW+1)-1:0] SEG_LEN = DEF_SEG_LEN
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              COPY_ROM,
    output logic              COPY_BUSY,
    output logic              COPY_ROM_COMPLETE,
    output logic              COPY_DONE_P,
    output logic [ROM_AW-1:0] ROM_ADDR,
    input  logic [DATA_W-1:0] ROM_DATA,
    output logic [RAM_AW-1:0] RAM_ADDR,
    output logic              RAM_WE,
    output logic [DATA_W-1:0] RAM_WDATA,
    input  logic [DATA_W-1:0] RAM_RDATA,
    input  logic              RE,
    input  logic              WR,
    input  logic [RAM_AW-1:0] ADDR,
    input  logic [DATA_W-1:0] WDATA,
    output logic [DATA_W-1:0] RDATA,
    output logic              RVALID,
    output logic              HOST_ERR
);

    copy_state_t       state;
    logic              copy_prev;
    logic              start_rise;
    logic              seq_load;
    logic              seq_step;
    logic [ROM_AW-1:0] seq_rom_addr;
    logic [RAM_AW-1:0] seq_ram_addr;
    logic              seq_wr;
    logic              seq_last;
    logic              seq_empty;
    logic              host_act;
    logic              host_rd;
    logic              host_drop;
    logic [DATA_W-1:0] rdata_hold;

    mod_seg_sequencer #(
        .ROM_AW (ROM_AW),
        .RAM_AW (RAM_AW),
        .NUM_SEG(NUM_SEG),
        .SEG_SRC(SEG_SRC),
        .SEG_DST(SEG_DST),
        .SEG_LEN(SEG_LEN)
    ) u_seq (
        .clk     (CLK),
        .rst_n   (RST_N),
        .load    (seq_load),
        .step    (seq_step),
        .rom_addr(seq_rom_addr),
        .ram_addr(seq_ram_addr),
        .wr_vld  (seq_wr),
        .last    (seq_last),
        .empty   (seq_empty)
    );

    always_comb begin
        start_rise = COPY_ROM && !copy_prev;
        seq_load   = (state == SETUP);
        seq_step   = (state == STREAM);
        host_act   = RST_N && !COPY_BUSY && (RE || WR);
        host_rd    = !COPY_BUSY && RE && !WR;
        host_drop  = (COPY_BUSY && (RE || WR)) || (!COPY_BUSY && RE && WR);
        ROM_ADDR   = seq_rom_addr;
        // The copy stream owns the RAM for the whole busy window.
        RAM_WE     = COPY_BUSY ? seq_wr : (host_act && WR);
        RAM_ADDR   = COPY_BUSY ? seq_ram_addr : (host_act ? ADDR : '0);
        RAM_WDATA  = COPY_BUSY ? ROM_DATA : WDATA;
        RDATA      = RVALID ? RAM_RDATA : rdata_hold;
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state             <= IDLE;
            copy_prev         <= 1'b1;
            COPY_BUSY         <= 1'b0;
            COPY_ROM_COMPLETE <= 1'b0;
            COPY_DONE_P       <= 1'b0;
            RVALID            <= 1'b0;
            HOST_ERR          <= 1'b0;
            rdata_hold        <= '0;
        end else begin
            copy_prev   <= COPY_ROM;
            COPY_DONE_P <= 1'b0;
            HOST_ERR    <= host_drop;
            RVALID      <= host_rd;
            if (RVALID) rdata_hold <= RAM_RDATA;
            case (state)
                IDLE: begin
                    if (start_rise) begin
                        state             <= SETUP;
                        COPY_BUSY         <= 1'b1;
                        COPY_ROM_COMPLETE <= 1'b0;
                    end
                end
                SETUP:  state <= seq_empty ? DRAIN : STREAM;
                STREAM: if (seq_last) state <= DRAIN;
                DRAIN: begin
                    state             <= IDLE;
                    COPY_BUSY         <= 1'b0;
                    COPY_ROM_COMPLETE <= 1'b1;
                    COPY_DONE_P       <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mod_rom_copy_dma.sv
// Directed bench for mod_rom_copy_dma: default SHA-256 table instance plus a
// three-segment instance with an empty middle segment.
module tb_mod_rom_copy_dma;

    logic        CLK;
    logic        RST_N;
    logic        COPY_ROM;
    logic        RE;
    logic        WR;
    logic [7:0]  ADDR;
    logic [31:0] WDATA;

    logic        busy_a, cmpl_a, done_a, we_a, rvalid_a, herr_a;
    logic [12:0] rom_addr_a;
    logic [7:0]  ram_addr_a;
    logic [31:0] wdata_a, rdata_a, ram_rdata_a, rom_data_a;

    logic        copy_b;
    logic        busy_b, cmpl_b, done_b, we_b, rvalid_b, herr_b;
    logic [12:0] rom_addr_b;
    logic [7:0]  ram_addr_b;
    logic [31:0] wdata_b, rdata_b, ram_rdata_b, rom_data_b;

    logic [31:0] mem_a [256];
    logic [31:0] mem_b [256];
    logic        mem_init = 1'b0;
    int          done_cnt_a = 0;
    int          wr_cnt_b = 0;

    int n_cmp = 0;
    int n_fail = 0;

    mod_rom_copy_dma u_dut_a (
        .CLK(CLK), .RST_N(RST_N), .COPY_ROM(COPY_ROM),
        .COPY_BUSY(busy_a), .COPY_ROM_COMPLETE(cmpl_a), .COPY_DONE_P(done_a),
        .ROM_ADDR(rom_addr_a), .ROM_DATA(rom_data_a),
        .RAM_ADDR(ram_addr_a), .RAM_WE(we_a), .RAM_WDATA(wdata_a), .RAM_RDATA(ram_rdata_a),
        .RE(RE), .WR(WR), .ADDR(ADDR), .WDATA(WDATA),
        .RDATA(rdata_a), .RVALID(rvalid_a), .HOST_ERR(herr_a)
    );

    mod_rom_copy_dma #(
        .NUM_SEG(3),
        .SEG_SRC({13'd20, 13'd10, 13'd0}),
        .SEG_DST({8'd100, 8'd50, 8'd0}),
        .SEG_LEN({9'd4, 9'd0, 9'd5})
    ) u_dut_b (
        .CLK(CLK), .RST_N(RST_N), .COPY_ROM(copy_b),
        .COPY_BUSY(busy_b), .COPY_ROM_COMPLETE(cmpl_b), .COPY_DONE_P(done_b),
        .ROM_ADDR(rom_addr_b), .ROM_DATA(rom_data_b),
        .RAM_ADDR(ram_addr_b), .RAM_WE(we_b), .RAM_WDATA(wdata_b), .RAM_RDATA(ram_rdata_b),
        .RE(1'b0), .WR(1'b0), .ADDR(8'd0), .WDATA(32'd0),
        .RDATA(rdata_b), .RVALID(rvalid_b), .HOST_ERR(herr_b)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // ROM returns 0xA5000000 + address; RAMs start with a recognisable fill.
    always @(posedge CLK) begin
        if (!mem_init) begin
            for (int i = 0; i < 256; i++) begin
                mem_a[i] <= 32'h1111_0000 + i;
                mem_b[i] <= 32'h2222_0000 + i;
            end
            mem_init <= 1'b1;
        end else begin
            if (we_a) mem_a[ram_addr_a] <= wdata_a;
            if (we_b) mem_b[ram_addr_b] <= wdata_b;
        end
        ram_rdata_a <= mem_a[ram_addr_a];
        ram_rdata_b <= mem_b[ram_addr_b];
        rom_data_a  <= 32'hA500_0000 + 32'(rom_addr_a);
        rom_data_b  <= 32'hA500_0000 + 32'(rom_addr_b);
        if (done_a) done_cnt_a <= done_cnt_a + 1;
        if (we_b) wr_cnt_b <= wr_cnt_b + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Waits for COPY_DONE_P on instance A; lat counts cycles after the start edge.
    task automatic run_copy(input bit poke, output int lat, output int herr);
        lat = -1;
        herr = 0;
        for (int c = 0; c < 400; c++) begin
            @(negedge CLK);
            if (herr_a) herr++;
            if (done_a) begin
                lat = c;
                break;
            end
            WR    = poke && (c == 10 || c == 11);
            RE    = poke && (c == 12);
            ADDR  = 8'h10;
            WDATA = 32'hBAD0_BAD0;
        end
        WR = 1'b0;
        RE = 1'b0;
    endtask

    initial begin
        int lat, herr, bad, d0;
        RST_N = 1'b1; COPY_ROM = 1'b0; copy_b = 1'b0;
        RE = 1'b0; WR = 1'b0; ADDR = '0; WDATA = '0;
        #2 RST_N = 1'b0;
        #1;
        check("rst_busy", busy_a, 0);
        check("rst_complete", cmpl_a, 0);
        check("rst_done", done_a, 0);
        check("rst_we", we_a, 0);
        check("rst_rvalid", rvalid_a, 0);
        check("rst_herr", herr_a, 0);
        check("rst_rdata", rdata_a, 0);
        check("rst_rom_addr", 32'(rom_addr_a), 0);
        check("rst_ram_addr", 32'(ram_addr_a), 0);
        repeat (3) @(negedge CLK);
        RST_N = 1'b1;
        repeat (3) @(negedge CLK);

        // Copy with host requests poked in while busy
        COPY_ROM = 1'b1;
        run_copy(1'b1, lat, herr);
        COPY_ROM = 1'b0;
        check("copy1_latency", lat, 74);
        check("copy1_host_err_pulses", herr, 3);
        check("copy1_busy_off", busy_a, 0);
        check("copy1_complete", cmpl_a, 1);
        @(negedge CLK);
        check("done_one_cycle", done_a, 0);
        bad = 0;
        for (int i = 0; i < 8; i++) if (mem_a[i] !== 32'hA500_0000 + i) bad++;
        check("ram_h0_block", bad, 0);
        bad = 0;
        for (int i = 64; i < 128; i++) if (mem_a[i] !== 32'hA500_0008 + (i - 64)) bad++;
        check("ram_k_block", bad, 0);
        bad = 0;
        for (int i = 8; i < 64; i++) if (mem_a[i] !== 32'h1111_0000 + i) bad++;
        check("ram_gap_untouched", bad, 0);
        check("ram_last_k", mem_a[127], 32'hA500_0047);
        check("ram_host_addr_kept", mem_a[16], 32'h1111_0010);

        // Host write then read after completion
        WR = 1'b1; ADDR = 8'h10; WDATA = 32'hDEAD_BEEF;
        #1;
        check("host_wr_we", we_a, 1);
        check("host_wr_addr", 32'(ram_addr_a), 32'h10);
        check("host_wr_data", wdata_a, 32'hDEAD_BEEF);
        @(negedge CLK);
        WR = 1'b0; RE = 1'b1;
        @(negedge CLK);
        RE = 1'b0;
        check("host_rvalid", rvalid_a, 1);
        check("host_rdata", rdata_a, 32'hDEAD_BEEF);
        check("host_no_err", herr_a, 0);
        @(negedge CLK);
        check("host_rvalid_drop", rvalid_a, 0);

        // Simultaneous RE+WR while idle
        RE = 1'b1; WR = 1'b1; ADDR = 8'h20; WDATA = 32'h1234_5678;
        @(negedge CLK);
        RE = 1'b0; WR = 1'b0;
        check("rewr_herr", herr_a, 1);
        check("rewr_rvalid", rvalid_a, 0);
        @(negedge CLK);
        check("rewr_herr_single", herr_a, 0);
        check("rewr_write_landed", mem_a[32], 32'h1234_5678);

        // COPY_ROM held high: one copy only, then a fresh edge restarts
        d0 = done_cnt_a;
        COPY_ROM = 1'b1;
        repeat (200) @(negedge CLK);
        check("hold_one_copy", done_cnt_a - d0, 1);
        check("hold_complete", cmpl_a, 1);
        COPY_ROM = 1'b0;
        repeat (3) @(negedge CLK);
        check("low_complete", cmpl_a, 1);
        COPY_ROM = 1'b1;
        @(negedge CLK);
        check("restart_complete_drop", cmpl_a, 0);
        check("restart_busy", busy_a, 1);
        run_copy(1'b0, lat, herr);
        check("restart_latency", lat, 73);
        repeat (2) @(negedge CLK);
        check("two_copies", done_cnt_a - d0, 2);
        COPY_ROM = 1'b0;
        @(negedge CLK);

        // Reset in the middle of a copy, with COPY_ROM held through reset
        COPY_ROM = 1'b1;
        repeat (32) @(negedge CLK);
        check("midcopy_busy", busy_a, 1);
        RST_N = 1'b0;
        #1;
        check("abort_busy", busy_a, 0);
        check("abort_complete", cmpl_a, 0);
        check("abort_we", we_a, 0);
        check("abort_rom_addr", 32'(rom_addr_a), 0);
        check("abort_ram_addr", 32'(ram_addr_a), 0);
        @(negedge CLK);
        RST_N = 1'b1;
        repeat (3) @(negedge CLK);
        check("held_high_no_start", busy_a, 0);
        COPY_ROM = 1'b0;
        @(negedge CLK);
        COPY_ROM = 1'b1;
        run_copy(1'b0, lat, herr);
        COPY_ROM = 1'b0;
        check("post_reset_latency", lat, 74);
        check("post_reset_complete", cmpl_a, 1);

        // Three-segment table with an empty middle segment
        copy_b = 1'b1;
        lat = -1;
        for (int c = 0; c < 100; c++) begin
            @(negedge CLK);
            if (done_b) begin
                lat = c;
                break;
            end
        end
        copy_b = 1'b0;
        check("seg3_latency", lat, 11);
        check("seg3_writes", wr_cnt_b, 9);
        bad = 0;
        for (int i = 0; i < 5; i++) if (mem_b[i] !== 32'hA500_0000 + i) bad++;
        for (int i = 100; i < 104; i++) if (mem_b[i] !== 32'hA500_0014 + (i - 100)) bad++;
        check("seg3_contents", bad, 0);
        check("seg3_word4", mem_b[4], 32'hA500_0004);
        check("seg3_word103", mem_b[103], 32'hA500_0017);
        check("seg3_empty_dst_kept", mem_b[50], 32'h2222_0032);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
